col_result_drain: RTL

- Sits directly downstream of the PE array, one instance per array column.
- Captures the ROWS per-PE accumulator results of its column as each PE raises its result-valid strobe.
- Buffers each result in a per-row slot and serializes the slots onto a single valid/ready output stream, lowest row first.
- Flags the end of a tile when ROWS results have been drained, and flags overflow when a slot is overwritten.

---
 rtl/systola_pkg.sv | 14 +
 rtl/lsb_first_pick.sv | 29 ++
 rtl/col_result_drain.sv | 109 ++++++++++
 3 files changed

// File: rtl/systola_pkg.sv
// Shared definitions for the systolic array datapath blocks: result width,
// result type and the row-index width helper.
package systola_pkg;

   localparam int unsigned OUTWIDTH_DEF = 32;

   typedef logic [OUTWIDTH_DEF-1:0] result_t;

   // At least one bit, so that a degenerate single-row column still has an index.
   function automatic int unsigned ridx_w(input int unsigned rows);
      return (rows > 1) ? int'($clog2(rows)) : 1;
   endfunction

endpackage

// File: rtl/lsb_first_pick.sv
// Combinational lowest-set-bit picker: one-hot grant plus binary index of the
// lowest asserted request bit.
module lsb_first_pick #(
   parameter int unsigned N  = 8,
   parameter int unsigned IW = 3
) (
   input  logic [N-1:0]  req,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && !found) begin
            grant[i] = 1'b1;
            idx      = IW'(i);
            found    = 1'b1;
         end
      end
      any = found;
   end

endmodule

// File: rtl/col_result_drain.sv
// Per-column result drain: captures per-row PE results into slots and serializes
// them lowest row first onto a valid/ready stream. Optional macro COL_DRAIN_RELU_EN.
module col_result_drain
   import systola_pkg::*;
#(
   parameter  int unsigned ROWS     = 8,
   parameter  int unsigned OUTWIDTH = OUTWIDTH_DEF,
   localparam int unsigned RIDX_W   = ridx_w(ROWS)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [OUTWIDTH-1:0] in_res    [0:ROWS-1],
   input  logic                in_valids [0:ROWS-1],
   output logic [OUTWIDTH-1:0] out_r,
   output logic [RIDX_W-1:0]   out_row,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                tile_done,
   output logic                overflow,
   input  logic                clr_ovf
);

   logic [OUTWIDTH-1:0] slot [0:ROWS-1];
   logic [ROWS-1:0]     full;
   logic [ROWS-1:0]     strobe;
   logic [ROWS-1:0]     grant;
   logic [ROWS-1:0]     unload;
   logic [RIDX_W-1:0]   pick_idx;
   logic [RIDX_W-1:0]   cnt;
   logic                pick_any;
   logic                load;
   logic                hs;
   logic                ovf_evt;
   logic [OUTWIDTH-1:0] load_val;

   lsb_first_pick #(
      .N  (ROWS),
      .IW (RIDX_W)
   ) u_pick (
      .req   (full),
      .grant (grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      strobe = '0;
      for (int unsigned i = 0; i < ROWS; i++) begin
         strobe[i] = in_valids[i];
      end
   end

   assign load      = !out_valid || out_ready;
   assign unload    = load ? grant : '0;
   // A strobe on a slot being unloaded this edge is a refill, not an overwrite.
   assign ovf_evt   = |(strobe & full & ~unload);
   assign hs        = out_valid && out_ready;
   assign tile_done = hs && (cnt == RIDX_W'(ROWS - 1));

   always_comb begin
      load_val = slot[pick_idx];
`ifdef COL_DRAIN_RELU_EN
      if (load_val[OUTWIDTH-1]) begin
         load_val = '0;
      end
`endif
   end

   // Slot data needs no reset; validity lives in the full flags.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
         if (strobe[i]) begin
            slot[i] <= in_res[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         full      <= '0;
         overflow  <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_r     <= '0;
         out_row   <= '0;
      end else begin
         full <= strobe | (full & ~unload);

         if (ovf_evt) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end

         if (hs) begin
            cnt <= tile_done ? '0 : cnt + 1'b1;
         end

         if (load) begin
            out_valid <= pick_any;
            if (pick_any) begin
               out_r   <= load_val;
               out_row <= pick_idx;
            end
         end
      end
   end

endmodule
